// File: rtl/snake_pkg.sv
// Types and field defaults shared by the snake game datapath blocks
// (diamond spawn controller, renderer, occupancy checker).
package snake_pkg;

  typedef logic [11:0] coord_t;

  typedef enum logic [2:0] {
    S_PLACED     = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_SAMPLE     = 3'd2,
    S_CHECK      = 3'd3,
    S_QUERY      = 3'd4,
    S_COMMIT     = 3'd5
  } spawn_state_e;

  localparam int FIELD_X_MIN_DEF = 16;
  localparam int FIELD_X_MAX_DEF = 470;
  localparam int FIELD_Y_MIN_DEF = 16;
  localparam int FIELD_Y_MAX_DEF = 630;
  localparam int DIAMOND_SIZE    = 10;
  localparam int DIAMOND_DEF_X   = 200;
  localparam int DIAMOND_DEF_Y   = 200;

  // Far-edge sums are formed one bit wider than a coordinate so they cannot wrap.
  function automatic logic in_field(
    input coord_t      x,
    input coord_t      y,
    input logic [12:0] x_min,
    input logic [12:0] x_max,
    input logic [12:0] y_min,
    input logic [12:0] y_max,
    input logic [12:0] size
  );
    logic [12:0] x_far;
    logic [12:0] y_far;
    x_far = {1'b0, x} + size;
    y_far = {1'b0, y} + size;
    return ({1'b0, x} >= x_min) && (x_far <= x_max) &&
           ({1'b0, y} >= y_min) && (y_far <= y_max);
  endfunction

endpackage

// File: rtl/diamond_spawn_ctrl.sv
// Diamond (food) placement sequencer: on eat, hides the diamond, waits for a
// frame boundary, then samples/validates random candidates and commits one.
module diamond_spawn_ctrl
  import snake_pkg::*;
#(
  parameter int FIELD_X_MIN = FIELD_X_MIN_DEF,
  parameter int FIELD_X_MAX = FIELD_X_MAX_DEF,
  parameter int FIELD_Y_MIN = FIELD_Y_MIN_DEF,
  parameter int FIELD_Y_MAX = FIELD_Y_MAX_DEF,
  parameter int SIZE        = DIAMOND_SIZE,
  parameter int MAX_TRIES   = 8,
  parameter int DEF_X       = DIAMOND_DEF_X,
  parameter int DEF_Y       = DIAMOND_DEF_Y,
  parameter int SCORE_W     = 8
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               game_over,
  input  logic               eat,
  input  logic               frame_tick,
  input  logic [11:0]        x_rand,
  input  logic [11:0]        y_rand,
  output logic               query_valid,
  output logic [11:0]        query_x,
  output logic [11:0]        query_y,
  input  logic               query_ack,
  input  logic               query_hit,
  output logic [11:0]        diamond_x,
  output logic [11:0]        diamond_y,
  output logic               diamond_valid,
  output logic               spawn_busy,
  output logic [SCORE_W-1:0] score
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam coord_t DEF_X_C = 12'(DEF_X);
  localparam coord_t DEF_Y_C = 12'(DEF_Y);

  spawn_state_e       r_state;
  logic [TRY_W-1:0]   r_try_cnt;
  coord_t             r_cand_x;
  coord_t             r_cand_y;
  coord_t             r_diamond_x;
  coord_t             r_diamond_y;
  logic               r_diamond_valid;
  logic               r_query_valid;
  logic               r_spawn_busy;
  logic [SCORE_W-1:0] r_score;

  logic               w_in_bounds;
  logic               w_last_try;

  // Candidate legality and retry-exhaustion decode.
  always_comb begin
    w_in_bounds = in_field(r_cand_x, r_cand_y,
                           13'(FIELD_X_MIN), 13'(FIELD_X_MAX),
                           13'(FIELD_Y_MIN), 13'(FIELD_Y_MAX), 13'(SIZE));
    w_last_try  = (r_try_cnt == LAST_TRY);
  end

  // Spawn FSM with all outputs held in registers; game_over acts as a reset.
  always_ff @(posedge vga_clk) begin
    if (!reset_n || game_over) begin
      r_state         <= S_PLACED;
      r_try_cnt       <= '0;
      r_cand_x        <= DEF_X_C;
      r_cand_y        <= DEF_Y_C;
      r_diamond_x     <= DEF_X_C;
      r_diamond_y     <= DEF_Y_C;
      r_diamond_valid <= 1'b1;
      r_query_valid   <= 1'b0;
      r_spawn_busy    <= 1'b0;
      r_score         <= '0;
    end else begin
      case (r_state)
        S_PLACED: begin
          if (eat) begin
            r_state         <= S_WAIT_FRAME;
            r_diamond_valid <= 1'b0;
            r_spawn_busy    <= 1'b1;
            r_try_cnt       <= '0;
            if (r_score != {SCORE_W{1'b1}}) begin
              r_score <= r_score + SCORE_W'(1);
            end
          end
        end
        S_WAIT_FRAME: begin
          if (frame_tick) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_cand_x <= x_rand;
          r_cand_y <= y_rand;
          r_state  <= S_CHECK;
        end
        S_CHECK: begin
          if (w_in_bounds) begin
            r_state       <= S_QUERY;
            r_query_valid <= 1'b1;
          end else if (w_last_try) begin
            r_cand_x <= DEF_X_C;
            r_cand_y <= DEF_Y_C;
            r_state  <= S_COMMIT;
          end else begin
            r_try_cnt <= r_try_cnt + TRY_W'(1);
            r_state   <= S_SAMPLE;
          end
        end
        S_QUERY: begin
          // Candidate registers double as the query address, so they stay put until ack.
          if (query_ack) begin
            r_query_valid <= 1'b0;
            if (!query_hit) begin
              r_state <= S_COMMIT;
            end else if (w_last_try) begin
              r_cand_x <= DEF_X_C;
              r_cand_y <= DEF_Y_C;
              r_state  <= S_COMMIT;
            end else begin
              r_try_cnt <= r_try_cnt + TRY_W'(1);
              r_state   <= S_SAMPLE;
            end
          end
        end
        S_COMMIT: begin
          r_diamond_x     <= r_cand_x;
          r_diamond_y     <= r_cand_y;
          r_diamond_valid <= 1'b1;
          r_spawn_busy    <= 1'b0;
          r_state         <= S_PLACED;
        end
        default: begin
          r_state       <= S_PLACED;
          r_query_valid <= 1'b0;
          r_spawn_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign query_valid   = r_query_valid;
  assign query_x       = r_cand_x;
  assign query_y       = r_cand_y;
  assign diamond_x     = r_diamond_x;
  assign diamond_y     = r_diamond_y;
  assign diamond_valid = r_diamond_valid;
  assign spawn_busy    = r_spawn_busy;
  assign score         = r_score;

endmodule

// File: tb/tb_diamond_spawn_ctrl.sv
// Self-checking bench for diamond_spawn_ctrl: table of respawn scenarios with a
// queue scoreboard, plus hand-written timing, retry, abort and saturation sequences.
module tb_diamond_spawn_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        game_over = 1'b0;
  logic        eat = 1'b0;
  logic        frame_tick = 1'b0;
  logic [11:0] x_rand = 12'd0;
  logic [11:0] y_rand = 12'd0;
  logic        query_valid;
  logic [11:0] query_x;
  logic [11:0] query_y;
  logic        query_ack = 1'b0;
  logic        query_hit = 1'b0;
  logic [11:0] diamond_x;
  logic [11:0] diamond_y;
  logic        diamond_valid;
  logic        spawn_busy;
  logic [7:0]  score;

  diamond_spawn_ctrl dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .game_over     (game_over),
    .eat           (eat),
    .frame_tick    (frame_tick),
    .x_rand        (x_rand),
    .y_rand        (y_rand),
    .query_valid   (query_valid),
    .query_x       (query_x),
    .query_y       (query_y),
    .query_ack     (query_ack),
    .query_hit     (query_hit),
    .diamond_x     (diamond_x),
    .diamond_y     (diamond_y),
    .diamond_valid (diamond_valid),
    .spawn_busy    (spawn_busy),
    .score         (score)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    int          hits;
    logic [11:0] ex;
    logic [11:0] ey;
  } vec_t;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    int          sc;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass = 0;
  int   exp_score = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic void push_exp(input logic [11:0] x, input logic [11:0] y);
    exp_t e;
    exp_score = (exp_score == 255) ? 255 : exp_score + 1;
    e.x = x;
    e.y = y;
    e.sc = exp_score;
    exp_q.push_back(e);
  endfunction

  task automatic pulse_eat();
    @(negedge vga_clk);
    eat = 1'b1;
    @(negedge vga_clk);
    eat = 1'b0;
  endtask

  task automatic tick(input logic [11:0] x, input logic [11:0] y);
    x_rand = x;
    y_rand = y;
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
  endtask

  // Acknowledges queries (hit for the first 'hits' of them) until the diamond reappears.
  task automatic wait_commit(input string name, input int hits);
    int   hl;
    bit   done;
    exp_t e;
    hl = hits;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (diamond_valid && !spawn_busy) begin
        done = 1'b1;
      end else begin
        query_ack = query_valid;
        query_hit = (hl > 0);
        if (query_valid && hl > 0) hl--;
        @(negedge vga_clk);
        query_ack = 1'b0;
        query_hit = 1'b0;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s_timeout: got busy expected commit within 300 cycles", name);
    end else if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s_sb: got commit expected empty scoreboard", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_x"}, int'(diamond_x), int'(e.x));
      check({name, "_y"}, int'(diamond_y), int'(e.y));
      check({name, "_score"}, int'(score), e.sc);
    end
  endtask

  task automatic run_spawn(input string name, input logic [11:0] x, input logic [11:0] y,
                           input int hits, input logic [11:0] ex, input logic [11:0] ey);
    push_exp(ex, ey);
    pulse_eat();
    tick(x, y);
    wait_commit(name, hits);
  endtask

  initial begin
    // Constant random inputs: an in-field value is accepted once query hits run out,
    // an out-of-field value exhausts every try and falls back to (200,200).
    vecs.push_back('{12'd100,  12'd300, 0, 12'd100, 12'd300});
    vecs.push_back('{12'd16,   12'd16,  0, 12'd16,  12'd16});
    vecs.push_back('{12'd460,  12'd620, 0, 12'd460, 12'd620});
    vecs.push_back('{12'd15,   12'd100, 0, 12'd200, 12'd200});
    vecs.push_back('{12'd100,  12'd15,  0, 12'd200, 12'd200});
    vecs.push_back('{12'd461,  12'd100, 0, 12'd200, 12'd200});
    vecs.push_back('{12'd100,  12'd621, 0, 12'd200, 12'd200});
    vecs.push_back('{12'd4095, 12'd4095,0, 12'd200, 12'd200});
    vecs.push_back('{12'd300,  12'd400, 3, 12'd300, 12'd400});
    vecs.push_back('{12'd50,   12'd60,  7, 12'd50,  12'd60});
    vecs.push_back('{12'd50,   12'd60,  8, 12'd200, 12'd200});

    // Reset
    repeat (2) @(negedge vga_clk);
    check("rst_x", int'(diamond_x), 200);
    check("rst_y", int'(diamond_y), 200);
    check("rst_valid", int'(diamond_valid), 1);
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(spawn_busy), 0);
    check("rst_qvalid", int'(query_valid), 0);
    reset_n = 1'b1;
    @(negedge vga_clk);

    // Nominal respawn with exact latency
    pulse_eat();
    exp_score = 1;
    check("nom_valid_after_eat", int'(diamond_valid), 0);
    check("nom_busy_after_eat", int'(spawn_busy), 1);
    check("nom_score", int'(score), 1);
    tick(12'd100, 12'd300);
    @(negedge vga_clk);
    check("nom_qvalid_early", int'(query_valid), 0);
    @(negedge vga_clk);
    check("nom_qvalid", int'(query_valid), 1);
    check("nom_qx", int'(query_x), 100);
    check("nom_qy", int'(query_y), 300);
    query_ack = 1'b1;
    query_hit = 1'b0;
    @(negedge vga_clk);
    query_ack = 1'b0;
    check("nom_valid_commit", int'(diamond_valid), 0);
    check("nom_qvalid_drop", int'(query_valid), 0);
    @(negedge vga_clk);
    check("nom_x", int'(diamond_x), 100);
    check("nom_y", int'(diamond_y), 300);
    check("nom_valid", int'(diamond_valid), 1);
    check("nom_busy", int'(spawn_busy), 0);

    // Bounds reject: two 2-cycle retries then acceptance; 461 is the first X
    // whose far edge passes the limit (460 still fits).
    push_exp(12'd120, 12'd50);
    pulse_eat();
    x_rand = 12'd5;
    y_rand = 12'd300;
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    @(negedge vga_clk);
    x_rand = 12'd461;
    @(negedge vga_clk);
    @(negedge vga_clk);
    x_rand = 12'd120;
    y_rand = 12'd50;
    @(negedge vga_clk);
    check("bnd_qvalid_early", int'(query_valid), 0);
    @(negedge vga_clk);
    @(negedge vga_clk);
    check("bnd_qvalid", int'(query_valid), 1);
    check("bnd_qx", int'(query_x), 120);
    wait_commit("bnd", 0);

    // Table of respawn scenarios
    foreach (vecs[i]) begin
      run_spawn($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].hits,
                vecs[i].ex, vecs[i].ey);
    end

    // Ignored eat during WAIT_FRAME
    push_exp(12'd100, 12'd100);
    pulse_eat();
    check("ign_score1", int'(score), exp_score);
    pulse_eat();
    check("ign_score2", int'(score), exp_score);
    check("ign_busy", int'(spawn_busy), 1);
    tick(12'd100, 12'd100);
    wait_commit("ign", 0);

    // Occupancy hits with slow ack: query held, then fallback after 8 tries
    push_exp(12'd200, 12'd200);
    pulse_eat();
    tick(12'd100, 12'd300);
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 20 && !query_valid; c++) @(negedge vga_clk);
      check($sformatf("fb_qvalid%0d", t), int'(query_valid), 1);
      x_rand = 12'd7;
      y_rand = 12'd9;
      for (int w = 0; w < 3; w++) begin
        @(negedge vga_clk);
        check($sformatf("fb_hold%0d_%0d", t, w), int'({query_x, query_y}),
              int'({12'd100, 12'd300}));
      end
      x_rand = 12'd100;
      y_rand = 12'd300;
      query_ack = 1'b1;
      query_hit = 1'b1;
      @(negedge vga_clk);
      query_ack = 1'b0;
      query_hit = 1'b0;
    end
    wait_commit("fb", 0);

    // Abort during QUERY
    pulse_eat();
    tick(12'd100, 12'd300);
    for (int c = 0; c < 20 && !query_valid; c++) @(negedge vga_clk);
    check("abt_qvalid_before", int'(query_valid), 1);
    game_over = 1'b1;
    @(negedge vga_clk);
    exp_q.delete();
    exp_score = 0;
    check("abt_qvalid", int'(query_valid), 0);
    check("abt_busy", int'(spawn_busy), 0);
    check("abt_score", int'(score), 0);
    check("abt_x", int'(diamond_x), 200);
    check("abt_y", int'(diamond_y), 200);
    check("abt_valid", int'(diamond_valid), 1);
    game_over = 1'b0;
    query_ack = 1'b1;
    query_hit = 1'b0;
    @(negedge vga_clk);
    query_ack = 1'b0;
    @(negedge vga_clk);
    check("abt_late_busy", int'(spawn_busy), 0);
    check("abt_late_valid", int'(diamond_valid), 1);
    check("abt_late_x", int'(diamond_x), 200);

    // Score saturation
    for (int k = 0; k < 256; k++) begin
      run_spawn($sformatf("sat%0d", k), 12'd40, 12'd40, 0, 12'd40, 12'd40);
    end
    check("sat_score", int'(score), 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
